// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter
// Round-robin time-sharing of an eight-digit hex 7-segment display between
// four 32-bit requesters. Each grant is held for DWELL cycles; iFREEZE pauses
// the dwell countdown. All outputs are registered, so there is no
// combinational path from the request inputs to oDIG.
//
// Optional feature: define SEG7_SRC_TAG_EN to replace digit 7 of oDIG with
// the owner index ({2'b00, oSRC}); otherwise oDIG carries the owner's word.
//
// Handshake: iREQ is a level request. A grant is signalled by a one-cycle
// pulse on oACK[g], and oDIG/oSRC reflect source g from that same cycle.
// A requester keeps iREQ high for as long as it wants to stay on screen.
// Nothing stalls on the display side, so there is no ready input.
//
// oSTATE exposes the FSM state for observation (0 = IDLE, 1 = HOLD).

module seg7_display_arbiter #(
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [3:0]  iREQ,
  input  logic [31:0] iDATA0,
  input  logic [31:0] iDATA1,
  input  logic [31:0] iDATA2,
  input  logic [31:0] iDATA3,
  input  logic        iFREEZE,
  output logic [31:0] oDIG,
  output logic [1:0]  oSRC,
  output logic [3:0]  oACK,
  output logic        oVALID,
  output logic        oSTATE
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Counter reload on a grant edge: the re-arbitration happens on the edge
  // where cnt is already 0, which gives exactly DWELL cycles per grant.
  localparam logic [31:0] DWELL_M1 = 32'(DWELL - 32'd1);

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [1:0]  rr_ptr, rr_ptr_n;
  logic [31:0] dig_n;
  logic [1:0]  src_n;
  logic [3:0]  ack_n;
  logic        valid_n;

  logic [31:0] data_arr [4];
  logic [1:0]  pick;
  logic        any_req;

  assign data_arr[0] = iDATA0;
  assign data_arr[1] = iDATA1;
  assign data_arr[2] = iDATA2;
  assign data_arr[3] = iDATA3;
  assign any_req     = |iREQ;
  assign oSTATE      = (state == HOLD);

  // Word shown on the display for a given owner index.
  function automatic logic [31:0] shown(input logic [31:0] d, input logic [1:0] s);
`ifdef SEG7_SRC_TAG_EN
    return {2'b00, s, d[27:0]};
`else
    return d ^ {30'd0, s & 2'b00};
`endif
  endfunction

  // Round-robin pick: first requesting source at or above rr_ptr, mod 4.
  always_comb begin
    pick = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (iREQ[rr_ptr + 2'(k)]) pick = rr_ptr + 2'(k);
    end
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rr_ptr_n = rr_ptr;
    dig_n    = oDIG;
    src_n    = oSRC;
    ack_n    = 4'b0000;
    valid_n  = oVALID;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_n  = HOLD;
          src_n    = pick;
          dig_n    = shown(data_arr[pick], pick);
          ack_n    = 4'b0001 << pick;
          valid_n  = 1'b1;
          cnt_n    = DWELL_M1;
          rr_ptr_n = pick + 2'd1;
        end
      end
      HOLD: begin
        // Live follow of the owner's data while it still requests.
        if (iREQ[oSRC]) dig_n = shown(data_arr[oSRC], oSRC);
        if (!iFREEZE) begin
          if (cnt != 32'd0) begin
            cnt_n = cnt - 32'd1;
          end else if (any_req) begin
            src_n    = pick;
            dig_n    = shown(data_arr[pick], pick);
            ack_n    = 4'b0001 << pick;
            valid_n  = 1'b1;
            cnt_n    = DWELL_M1;
            rr_ptr_n = pick + 2'd1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state  <= IDLE;
      cnt    <= 32'd0;
      rr_ptr <= 2'd0;
      oDIG   <= 32'd0;
      oSRC   <= 2'd0;
      oACK   <= 4'b0000;
      oVALID <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rr_ptr <= rr_ptr_n;
      oDIG   <= dig_n;
      oSRC   <= src_n;
      oACK   <= ack_n;
      oVALID <= valid_n;
    end
  end

endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Time-shares the board's eight-digit hexadecimal 7-segment display between four 32-bit requesters. It sits directly upstream of the 7-segment display decoder and drives that decoder's 32-bit digit word. A round-robin scheduler grants the display to one requester at a time. The granted source is held for a fixed dwell time, so each value stays on screen long enough to read. The block is fully synchronous to the pixel/system clock and has no combinational path from request inputs to the digit output.

## Interface
Parameters:
- DWELL, 50_000_000: hold time per grant in clock cycles (1 s at 50 MHz); legal range 1 to 2^32-1.

Ports:
- iCLK  input  1  system clock; all state on the rising edge.
- iRST_N  input  1  asynchronous, active-low reset.
- iREQ  input  4  level request per source; bit i high means source i wants the display.
- iDATA0..iDATA3  input  32 each  digit word of source i (nibble k → digit k).
- iFREEZE  input  1  while high, the dwell counter does not decrement (rotation paused).
- oDIG  output  32  digit word to the display decoder.
- oSRC  output  2  index of the current or last owner.
- oACK  output  4  one-cycle pulse on bit i when source i is granted.
- oVALID  output  1  low from reset until the first grant; high afterwards.

## Operation
- States: IDLE, HOLD.
- Reset values: IDLE, oDIG=0, oSRC=0, oACK=0, oVALID=0, rr_ptr=0, cnt=0.
- Round-robin pick: the first set bit of iREQ, searching upward (mod 4) from rr_ptr.
- IDLE:
  - If iREQ≠0, grant the picked source g and go to HOLD.
  - On the grant edge: oSRC=g, oDIG=iDATAg, oACK[g]=1, oVALID=1, cnt=DWELL-1, rr_ptr=g+1 (mod 4).
  - If iREQ=0, all registers hold; oDIG keeps its last value.
- HOLD:
  - Each cycle, if iREQ[oSRC]=1, oDIG follows iDATA[oSRC] with one register stage.
  - If iREQ[oSRC]=0, oDIG freezes at its last value.
  - If cnt≠0 and iFREEZE=0, cnt decrements by 1.
  - If cnt=0 and iFREEZE=0, re-arbitrate:
    - With iREQ≠0, perform a new grant exactly as in IDLE. The owner can be re-granted if it is the only requester; oACK pulses again.
    - With iREQ=0, go to IDLE; oDIG and oSRC hold.
  - If cnt=0 and iFREEZE=1, stay in HOLD with no re-arbitration.
- oACK is never set on more than one bit. It is 0 on every cycle that is not a grant edge.
- DWELL=1 gives a new grant on every cycle while requests are present.
- Reset asserted mid-HOLD: all registers return to reset values immediately, without waiting for a clock edge.

## Timing
- Request-to-display latency from IDLE: a request sampled at edge N produces oACK, oDIG and oSRC updated after edge N, valid in cycle N+1.
- Data-follow latency in HOLD: one cycle from iDATA to oDIG.
- Grant period with iFREEZE low: exactly DWELL cycles between consecutive grant edges while any request remains.
- iFREEZE pauses the count; the grant period is extended by the number of cycles iFREEZE was high.
- Simultaneous events:
  - A request rising on the same edge that cnt reaches 0 takes part in that arbitration.
  - A request dropping on that edge does not take part.

## Configuration
- SEG7_SRC_TAG_EN:
  - Defined: oDIG[31:28] = {2'b00, oSRC}, so digit 7 shows the source index 0–3. oDIG[27:0] behaves as specified above. The reset value of oDIG is still 0.
  - Undefined: oDIG carries all 32 bits of the owner's data unmodified.

## Test plan
All scenarios use DWELL=4.
- Reset/idle: hold iRST_N low, then release with iREQ=0 for 10 cycles → oDIG=0, oVALID=0, oACK=0, oSRC=0 throughout.
- Single requester: iREQ=4'b0100, iDATA2=32'h1234_5678 → one cycle later oACK=4'b0100, oSRC=2, oDIG=32'h1234_5678. oACK pulses again every 4 cycles. With SEG7_SRC_TAG_EN defined, oDIG=32'h2234_5678.
- Rotation: iREQ=4'b1011 held constant → grant order 0,1,3,0,…, each held exactly 4 cycles.
- Live follow and drop: owner 0 changes iDATA0 from 32'hAAAA_0000 to 32'hAAAA_0001 mid-hold → oDIG updates one cycle later. Then drop iREQ[0] with the other sources idle → oDIG stays 32'hAAAA_0001, state goes to IDLE after the dwell ends.
- Freeze: during owner 1's hold, pulse iFREEZE high for 6 cycles → the next grant arrives at 4+6=10 cycles after the grant edge.
- Reset mid-hold: assert iRST_N low asynchronously between clock edges while in HOLD → oDIG, oVALID and oACK clear without waiting for a clock edge.
